// File: rtl/bp_return_pkg.sv
// Shared return-path definitions: word tags, source indices and overflow report layout.
// The dispatcher imports the same tags so both directions share one word format.
package bp_return_pkg;

   localparam logic [7:0] TAG_SPI = 8'h00;
   localparam logic [7:0] TAG_AUX = 8'h01;
   localparam logic [7:0] TAG_EVT = 8'h02;
   localparam logic [7:0] TAG_OVF = 8'hFE;

   // Source indices double as the bit positions in the overflow report payload.
   localparam int unsigned SRC_SPI = 0;
   localparam int unsigned SRC_AUX = 1;
   localparam int unsigned SRC_EVT = 2;
   localparam int unsigned NUM_SRC = 3;

   typedef enum logic [2:0] {
      WIN_NONE,
      WIN_OVF,
      WIN_SPI,
      WIN_AUX,
      WIN_EVT
   } winner_e;

   function automatic logic [15:0] make_word(input logic [7:0] tag, input logic [7:0] data);
      return {tag, data};
   endfunction

   function automatic logic [7:0] ovf_payload(input logic [NUM_SRC-1:0] ovf);
      return {5'b0, ovf};
   endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for asynchronous input pins, synchronous active-high reset to 0.
module pin_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/result_return.sv
// Collects single-cycle result pulses into per-source holding registers and arbitrates
// them into tagged 16-bit words for the host-bound output FIFO, reporting drops in-band.
module result_return
   import bp_return_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        spi_rx_valid,
   input  logic [7:0]  spi_rx_data,
   input  logic        aux_sample_req,
   input  logic        bp_aux_in,
   input  logic        evt_valid,
   input  logic [7:0]  evt_code,
   input  logic        out_fifo_in_full,
   output logic        out_fifo_in_push,
   output logic [15:0] out_fifo_in_data,
   output logic        busy,
   output logic        overflow_seen
);

   logic                          aux_sync;

   logic [NUM_SRC-1:0]            valid_q, valid_d;
   logic [NUM_SRC-1:0][7:0]       data_q, data_d;
   logic [NUM_SRC-1:0]            ovf_q, ovf_d;
   logic                          overflow_seen_q, overflow_seen_d;

   logic [NUM_SRC-1:0]            pulse;
   logic [NUM_SRC-1:0][7:0]       payload;
   logic [NUM_SRC-1:0]            drain;
   logic [NUM_SRC-1:0]            new_ovf;
   logic                          drain_ovf;
   logic                          push;
   logic [15:0]                   word;
   winner_e                       winner;

   pin_sync #(
      .WIDTH(1)
   ) u_aux_sync (
      .clock (clock),
      .reset (reset),
      .d     (bp_aux_in),
      .q     (aux_sync)
   );

   always_comb begin
      pulse            = '0;
      payload          = '0;
      pulse[SRC_SPI]   = spi_rx_valid;
      payload[SRC_SPI] = spi_rx_data;
      pulse[SRC_AUX]   = aux_sample_req;
      payload[SRC_AUX] = {7'b0, aux_sync};
      pulse[SRC_EVT]   = evt_valid;
      payload[SRC_EVT] = evt_code;
   end

   // Fixed priority: pending overflow report first, then SPI, AUX, EVT.
   always_comb begin
      winner = WIN_NONE;
      if (|ovf_q)
         winner = WIN_OVF;
      else if (valid_q[SRC_SPI])
         winner = WIN_SPI;
      else if (valid_q[SRC_AUX])
         winner = WIN_AUX;
      else if (valid_q[SRC_EVT])
         winner = WIN_EVT;
   end

   always_comb begin
      word = '0;
      case (winner)
         WIN_OVF: word = make_word(TAG_OVF, ovf_payload(ovf_q));
         WIN_SPI: word = make_word(TAG_SPI, data_q[SRC_SPI]);
         WIN_AUX: word = make_word(TAG_AUX, data_q[SRC_AUX]);
         WIN_EVT: word = make_word(TAG_EVT, data_q[SRC_EVT]);
         default: word = '0;
      endcase
   end

   always_comb begin
      push           = (winner != WIN_NONE) && !out_fifo_in_full;
      drain          = '0;
      drain[SRC_SPI] = push && (winner == WIN_SPI);
      drain[SRC_AUX] = push && (winner == WIN_AUX);
      drain[SRC_EVT] = push && (winner == WIN_EVT);
      drain_ovf      = push && (winner == WIN_OVF);
   end

   // A pulse is accepted if the register is empty or being drained this cycle;
   // otherwise it is dropped, the held payload is kept and the drop is flagged.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      new_ovf = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (drain[i])
            valid_d[i] = 1'b0;
         if (pulse[i]) begin
            if (!valid_q[i] || drain[i]) begin
               valid_d[i] = 1'b1;
               data_d[i]  = payload[i];
            end else begin
               new_ovf[i] = 1'b1;
            end
         end
      end
      ovf_d           = (drain_ovf ? '0 : ovf_q) | new_ovf;
      overflow_seen_d = overflow_seen_q | (|new_ovf);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q         <= '0;
         data_q          <= '0;
         ovf_q           <= '0;
         overflow_seen_q <= 1'b0;
      end else begin
         valid_q         <= valid_d;
         data_q          <= data_d;
         ovf_q           <= ovf_d;
         overflow_seen_q <= overflow_seen_d;
      end
   end

   assign out_fifo_in_push = push;
   assign out_fifo_in_data = word;
   assign busy             = (|valid_q) | (|ovf_q);
   assign overflow_seen    = overflow_seen_q;

endmodule

// File: tb/tb_result_return.sv
// Directed-vector bench for result_return with hand-computed expected words.
module tb_result_return;

   logic        clock;
   logic        reset;
   logic        spi_rx_valid;
   logic [7:0]  spi_rx_data;
   logic        aux_sample_req;
   logic        bp_aux_in;
   logic        evt_valid;
   logic [7:0]  evt_code;
   logic        out_fifo_in_full;
   logic        out_fifo_in_push;
   logic [15:0] out_fifo_in_data;
   logic        busy;
   logic        overflow_seen;

   int unsigned n_pass;
   int unsigned n_total;

   result_return dut (
      .clock            (clock),
      .reset            (reset),
      .spi_rx_valid     (spi_rx_valid),
      .spi_rx_data      (spi_rx_data),
      .aux_sample_req   (aux_sample_req),
      .bp_aux_in        (bp_aux_in),
      .evt_valid        (evt_valid),
      .evt_code         (evt_code),
      .out_fifo_in_full (out_fifo_in_full),
      .out_fifo_in_push (out_fifo_in_push),
      .out_fifo_in_data (out_fifo_in_data),
      .busy             (busy),
      .overflow_seen    (overflow_seen)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_push(input string tag, input logic [15:0] word);
      check({tag, ".push"}, 32'(out_fifo_in_push), 32'd1);
      check({tag, ".data"}, 32'(out_fifo_in_data), 32'(word));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".push"}, 32'(out_fifo_in_push), 32'd0);
      check({tag, ".data"}, 32'(out_fifo_in_data), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_pass           = 0;
      n_total          = 0;
      reset            = 1'b1;
      spi_rx_valid     = 1'b0;
      spi_rx_data      = 8'h00;
      aux_sample_req   = 1'b0;
      bp_aux_in        = 1'b0;
      evt_valid        = 1'b0;
      evt_code         = 8'h00;
      out_fifo_in_full = 1'b0;

      // reset state
      tick();
      tick();
      expect_idle("rst");
      check("rst.ovf_seen", 32'(overflow_seen), 32'd0);
      reset = 1'b0;
      #1;
      expect_idle("rst_rel");

      // single SPI byte
      spi_rx_valid = 1'b1;
      spi_rx_data  = 8'hA5;
      tick();
      spi_rx_valid = 1'b0;
      #1;
      expect_push("spi1", 16'h00A5);
      check("spi1.busy", 32'(busy), 32'd1);
      tick();
      expect_idle("spi1_after");

      // AUX sample after level settles through the synchronizer
      bp_aux_in = 1'b1;
      tick();
      tick();
      tick();
      aux_sample_req = 1'b1;
      tick();
      aux_sample_req = 1'b0;
      #1;
      expect_push("aux1", 16'h0101);
      tick();
      expect_idle("aux1_after");
      bp_aux_in = 1'b0;
      tick();
      tick();
      tick();

      // simultaneous pulses on all sources
      spi_rx_valid   = 1'b1;
      spi_rx_data    = 8'h11;
      aux_sample_req = 1'b1;
      evt_valid      = 1'b1;
      evt_code       = 8'h33;
      tick();
      spi_rx_valid   = 1'b0;
      aux_sample_req = 1'b0;
      evt_valid      = 1'b0;
      #1;
      expect_push("all.spi", 16'h0011);
      tick();
      expect_push("all.aux", 16'h0100);
      tick();
      expect_push("all.evt", 16'h0233);
      tick();
      expect_idle("all_after");
      check("all.ovf_seen", 32'(overflow_seen), 32'd0);

      // overflow while full, report precedes the held byte
      out_fifo_in_full = 1'b1;
      spi_rx_valid     = 1'b1;
      spi_rx_data      = 8'h01;
      tick();
      spi_rx_data      = 8'h02;
      tick();
      spi_rx_valid     = 1'b0;
      #1;
      check("ovf.push_full", 32'(out_fifo_in_push), 32'd0);
      check("ovf.seen", 32'(overflow_seen), 32'd1);
      check("ovf.busy", 32'(busy), 32'd1);
      tick();
      check("ovf.push_full2", 32'(out_fifo_in_push), 32'd0);
      out_fifo_in_full = 1'b0;
      #1;
      expect_push("ovf.report", 16'hFE01);
      tick();
      expect_push("ovf.held", 16'h0001);
      tick();
      expect_idle("ovf_after");
      check("ovf.seen_sticky", 32'(overflow_seen), 32'd1);

      // back-to-back SPI, refill on drain every cycle
      for (int i = 0; i <= 8; i++) begin
         spi_rx_valid = (i < 8);
         spi_rx_data  = 8'h40 + 8'(i);
         #1;
         if (i > 0)
            expect_push($sformatf("stream%0d", i - 1), 16'h0040 + 16'(i - 1));
         tick();
      end
      spi_rx_valid = 1'b0;
      #1;
      expect_idle("stream_after");

      // reset with a pending EVT and full FIFO discards everything
      out_fifo_in_full = 1'b1;
      evt_valid        = 1'b1;
      evt_code         = 8'h77;
      tick();
      evt_valid        = 1'b0;
      #1;
      check("rstmid.busy_before", 32'(busy), 32'd1);
      check("rstmid.push_before", 32'(out_fifo_in_push), 32'd0);
      check("rstmid.data_before", 32'(out_fifo_in_data), 32'h0277);
      reset = 1'b1;
      tick();
      reset            = 1'b0;
      out_fifo_in_full = 1'b0;
      #1;
      expect_idle("rstmid");
      check("rstmid.ovf_seen", 32'(overflow_seen), 32'd0);
      tick();
      expect_idle("rstmid2");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/result_return.md
# result_return

Return-path collector between the protocol facade/dispatcher and the host-bound output FIFO. Captures single-cycle result pulses (SPI receive byte, AUX pin sample, dispatcher event codes) into per-source holding registers. Arbitrates them into tagged 16-bit words `{tag[15:8], data[7:0]}` and pushes one word per cycle into the output FIFO. This uses the same word layout as the command stream the dispatcher pops. Dropped results are reported in-band with an overflow word, never silently.

## Interface
- `TAG_SPI`, 8'h00: tag for SPI receive byte.
- `TAG_AUX`, 8'h01: tag for AUX sample; data = `{7'b0, level}`.
- `TAG_EVT`, 8'h02: tag for dispatcher event code.
- `TAG_OVF`, 8'hFE: tag for overflow report; data = `{5'b0, evt_ovf, aux_ovf, spi_ovf}`.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `spi_rx_valid` in 1: one-cycle pulse, SPI byte available.
- `spi_rx_data` in 8: SPI byte, valid with `spi_rx_valid`.
- `aux_sample_req` in 1: one-cycle pulse, sample AUX pin.
- `bp_aux_in` in 1: asynchronous AUX pin level.
- `evt_valid` in 1: one-cycle pulse, dispatcher event.
- `evt_code` in 8: event code, valid with `evt_valid`.
- `out_fifo_in_full` in 1: output FIFO full; a push while high is lost.
- `out_fifo_in_push` out 1: push strobe, combinational.
- `out_fifo_in_data` out 16: word pushed, combinational.
- `busy` out 1: any holding register valid or overflow report pending.
- `overflow_seen` out 1: sticky, set on any drop, cleared only by reset.

## Operation
- Three holding registers: SPI, AUX, EVT. Each has a `valid` flag and an 8-bit payload.
- Capture: a source pulse loads its register and sets `valid` at the clock edge.
- AUX path: `bp_aux_in` passes through a 2-flop synchronizer (reset 0). `aux_sample_req` captures the synchronized level.
- Overflow: a pulse arriving while its register is valid and not being drained that cycle is dropped. The drop sets that source's `ovf` bit and `overflow_seen`. The held payload is kept.
- Refill-on-drain: a pulse in the same cycle its register drains is accepted. No overflow is recorded.
- Arbiter (fixed priority): OVF report (any `ovf` bit set) > SPI > AUX > EVT.
- Push: `out_fifo_in_push = winner_exists & !out_fifo_in_full`. Data comes from the winner mux; `out_fifo_in_data` = 16'h0000 when no winner.
- On push, the winning register clears `valid`. For an OVF report, the reported `ovf` bits clear. Bits newly set in that same cycle remain set.
- While `out_fifo_in_full` is high: no push, no state change except captures and overflow marking.
- `busy` = OR of the three `valid` flags and the `ovf` bits.

## Timing
- Reset: all `valid` = 0, `ovf` = 0, `overflow_seen` = 0, synchronizer = 0. Consequently `out_fifo_in_push` = 0 and `out_fifo_in_data` = 0 during and after reset.
- Reset mid-operation discards pending results without reporting them.
- Latency: a pulse in cycle N produces a push in cycle N+1 when the FIFO is not full and no higher-priority source is pending.
- AUX level change to sampled value: 2 cycles of synchronizer latency before `aux_sample_req` sees it.
- Throughput: 1 word/cycle. Each source sustains a pulse every cycle only while it wins arbitration and the FIFO is not full.
- Simultaneous pulses on all three sources in cycle N: pushes SPI at N+1, AUX at N+2, EVT at N+3.
- The full flag is sampled combinationally in the push cycle. There is no registered lookahead, so full may deassert and push in the same cycle.

## Structure
- Shared package `bp_return_pkg`: the four tag constants, source index constants (SPI=0, AUX=1, EVT=2), and the OVF data bit layout. The dispatcher imports the same tags.
- One sub-module `pin_sync`: 2-flop synchronizer with synchronous reset, reused for future input pins.
- Arbiter and holding registers are inline in `result_return`.

## Test plan
- Single SPI pulse, data 8'hA5, FIFO empty -> one push next cycle, data 16'h00A5; `busy` low afterwards.
- `bp_aux_in` = 1 for 3 cycles, then `aux_sample_req` -> push 16'h0101 one cycle later.
- SPI 8'h11, AUX with level 0, EVT 8'h33, all in the same cycle -> pushes 16'h0011, 16'h0100, 16'h0233 on three consecutive cycles.
- FIFO full held; SPI 8'h01 then SPI 8'h02 -> `overflow_seen` = 1, no push while full. On release: 16'hFE01, then 16'h0001. Byte 8'h02 is never emitted.
- SPI pulses every cycle for 8 cycles with FIFO never full -> 8 consecutive pushes, data 16'h00xx in order, no overflow.
- Reset asserted while the EVT register is valid and the FIFO is full -> after reset no push occurs, `busy` = 0, `overflow_seen` = 0.
